// File: rtl/uart_mem_loader.sv
// uart_mem_loader: 8N1 UART receiver that packs WORD_BYTES bytes into one
// RAM word and writes it through the RAM second write port at an
// auto-incrementing word address.
//
// Ports:
//   clk, reset              system clock / synchronous active-high reset
//   serialIn                asynchronous RX line (idle high)
//   setAddr, startAddr      one-cycle pointer load; also clears the partial
//                           word, wordCount and err
//   writeEnable/Addr/Data   RAM write port (wEn2/addr2/dataIn2)
//   lastByte, byteValid     most recent good byte and its one-cycle strobe
//   err                     sticky framing error (bad stop bit)
//   wordCount               words written since last setAddr/reset

// One byte lane of the word assembly buffer.
module uart_mem_loader_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    if (load) lane_d = din;
  end

  always_ff @(posedge clk) begin
    if (reset) lane_q <= '0;
    else       lane_q <= lane_d;
  end

  assign dout = lane_q;
endmodule

module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES   = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    serialIn,
  input  logic                    setAddr,
  input  logic [ADDR_WIDTH-1:0]   startAddr,
  output logic                    writeEnable,
  output logic [ADDR_WIDTH-1:0]   writeAddr,
  output logic [8*WORD_BYTES-1:0] writeData,
  output logic [7:0]              lastByte,
  output logic                    byteValid,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   wordCount
);
  localparam int DW   = 8 * WORD_BYTES;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(WORD_BYTES + 1);
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  byte_valid_q, byte_valid_d;
  logic [7:0]            last_byte_q, last_byte_d;
  logic                  err_q, err_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] wcount_q, wcount_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [TW-1:0]         idle_q, idle_d;

  logic                         rx;
  logic                         good, bad;
  logic [WORD_BYTES-1:0]        lane_load;
  logic [WORD_BYTES-1:0][7:0]   lanes;

  assign rx = sync2_q;

  for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
    uart_mem_loader_lane u_lane (
      .clk  (clk),
      .reset(reset),
      .load (lane_load[g]),
      .din  (shift_q),
      .dout (lanes[g])
    );
  end

  // RX framing FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sync1_d = serialIn;
    sync2_d = sync1_q;
    good    = 1'b0;
    bad     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = START;
      end
      START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at mid start bit: treat the edge as a glitch.
          state_d = rx ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          good    = rx;
          bad     = !rx;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word assembly, write issue, timeout and pointer control
  always_comb begin
    byte_valid_d = 1'b0;
    last_byte_d  = last_byte_q;
    err_d        = err_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    wcount_d     = wcount_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    idle_d       = idle_q;
    lane_load    = '0;

    // Final byte of a word was accepted last cycle: issue the write now.
    if (byte_valid_q && idx_q == IW'(WORD_BYTES)) begin
      we_d     = 1'b1;
      waddr_d  = ptr_q;
      wdata_d  = lanes;
      ptr_d    = ptr_q + 1'b1;
      wcount_d = wcount_q + 1'b1;
      idx_d    = '0;
    end

    // Idle counter only runs while a partial word is held.
    if (byte_valid_q || idx_q == '0) begin
      idle_d = '0;
    end else if (idle_q == TW'(TIMEOUT_CLKS)) begin
      idle_d = '0;
      idx_d  = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    // setAddr overrides the pointer even on a write cycle; the write itself
    // already captured the old pointer.
    if (setAddr) begin
      ptr_d    = startAddr;
      idx_d    = '0;
      wcount_d = '0;
      err_d    = 1'b0;
    end

    if (bad) err_d = 1'b1;

    if (good) begin
      byte_valid_d = 1'b1;
      last_byte_d  = shift_q;
      for (int i = 0; i < WORD_BYTES; i++)
        if (idx_d == IW'(i)) lane_load[i] = 1'b1;
      idx_d = idx_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      byte_valid_q <= 1'b0;
      last_byte_q  <= '0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      ptr_q        <= '0;
      wcount_q     <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      byte_valid_q <= byte_valid_d;
      last_byte_q  <= last_byte_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      wcount_q     <= wcount_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      idle_q       <= idle_d;
    end
  end

  assign writeEnable = we_q;
  assign writeAddr   = waddr_q;
  assign writeData   = wdata_q;
  assign lastByte    = last_byte_q;
  assign byteValid   = byte_valid_q;
  assign err         = err_q;
  assign wordCount   = wcount_q;
endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: stimulus tasks update a byte/word
// reference model and push expected bytes and writes; a negedge monitor pops
// and compares whenever byteValid or writeEnable is seen.
module tb_uart_mem_loader;
  localparam int CPB = 16;
  localparam int WB  = 4;
  localparam int AW  = 12;
  localparam int TO  = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          serialIn;
  logic          setAddr;
  logic [AW-1:0] startAddr;
  logic          writeEnable;
  logic [AW-1:0] writeAddr;
  logic [8*WB-1:0] writeData;
  logic [7:0]    lastByte;
  logic          byteValid;
  logic          err;
  logic [AW-1:0] wordCount;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .ADDR_WIDTH(AW),
                    .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .serialIn(serialIn), .setAddr(setAddr),
    .startAddr(startAddr), .writeEnable(writeEnable), .writeAddr(writeAddr),
    .writeData(writeData), .lastByte(lastByte), .byteValid(byteValid),
    .err(err), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [8*WB-1:0] d; } wr_t;

  int checks = 0;
  int passes = 0;

  // reference model
  logic [7:0]    exp_bytes[$];
  wr_t           exp_wr[$];
  logic [7:0]    mdl_lane[$];
  logic [AW-1:0] mdl_ptr = '0;
  logic [AW-1:0] mdl_cnt = '0;
  logic          mdl_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic void model_good(input logic [7:0] b);
    wr_t w;
    exp_bytes.push_back(b);
    mdl_lane.push_back(b);
    if (mdl_lane.size() == WB) begin
      w.a = mdl_ptr;
      w.d = '0;
      for (int i = 0; i < WB; i++) w.d[8*i +: 8] = mdl_lane[i];
      exp_wr.push_back(w);
      mdl_ptr = mdl_ptr + 1'b1;
      mdl_cnt = mdl_cnt + 1'b1;
      mdl_lane.delete();
    end
  endfunction

  function automatic void model_set(input logic [AW-1:0] a);
    mdl_ptr = a;
    mdl_cnt = '0;
    mdl_err = 1'b0;
    mdl_lane.delete();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one 8N1 frame. A bad frame holds the stop bit low only long enough
  // to cover the receiver's mid-bit sample, then idles high.
  task automatic send(input logic [7:0] b, input bit good_stop);
    if (good_stop) model_good(b);
    else mdl_err = 1'b1;
    serialIn = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      tick(CPB);
    end
    if (good_stop) begin
      serialIn = 1'b1;
      tick(CPB);
    end else begin
      serialIn = 1'b0;
      tick(12);
      serialIn = 1'b1;
      tick(CPB);
    end
  endtask

  task automatic pulse_set(input logic [AW-1:0] a);
    startAddr = a;
    setAddr   = 1'b1;
    tick(1);
    setAddr   = 1'b0;
    model_set(a);
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_we"},    writeEnable, 0);
    chk({tag, "_bv"},    byteValid, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_waddr"}, writeAddr, 0);
    chk({tag, "_wdata"}, writeData, 0);
    chk({tag, "_last"},  lastByte, 0);
    chk({tag, "_wc"},    wordCount, 0);
  endtask

  // monitor
  logic prev_bv = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (byteValid) begin
        if (exp_bytes.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byteValid actual=%0h required=none", lastByte);
        end else begin
          chk("lastByte", lastByte, exp_bytes.pop_front());
        end
      end
      if (writeEnable) begin
        chk("we_latency", prev_bv, 1);
        chk("we_bv_overlap", byteValid, 0);
        if (exp_wr.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", writeAddr, writeData);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("writeAddr", writeAddr, w.a);
          chk("writeData", writeData, w.d);
        end
      end
      prev_bv <= byteValid;
    end else begin
      prev_bv <= 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    reset = 1'b1; serialIn = 1'b1; setAddr = 1'b0; startAddr = '0;
    tick(3);
    check_reset_vals("rst0");
    reset = 1'b0;
    tick(5);

    // 1: single byte
    send(8'h55, 1'b1);
    tick(4);
    chk("t1_err", err, 0);
    chk("t1_wc", wordCount, mdl_cnt);

    // 2: two words from 0x100
    pulse_set(12'h100);
    send(8'h78, 1); send(8'h56, 1); send(8'h34, 1); send(8'h12, 1);
    send(8'hEF, 1); send(8'hBE, 1); send(8'hAD, 1); send(8'hDE, 1);
    tick(4);
    chk("t2_wc", wordCount, mdl_cnt);

    // 3: bad stop in the middle of a word leaves the byte index alone
    send(8'h11, 1); send(8'h22, 1); send(8'hA5, 0); send(8'h33, 1); send(8'h44, 1);
    tick(4);
    chk("t3_err", err, mdl_err);
    pulse_set(12'h200);
    tick(2);
    chk("t3_err_clr", err, mdl_err);
    chk("t3_wc_clr", wordCount, mdl_cnt);

    // 4: short low glitch
    serialIn = 1'b0; tick(4); serialIn = 1'b1; tick(40);
    chk("t4_err", err, 0);

    // 5: pointer wrap
    pulse_set(12'hFFF);
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 1);
    tick(4);
    chk("t5_wc", wordCount, mdl_cnt);

    // 6: partial word timeout
    send(8'hC1, 1); send(8'hC2, 1);
    tick(TO + 1);
    mdl_lane.delete();
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 1);
    tick(4);
    chk("t6_wc", wordCount, mdl_cnt);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(5) == 0) pulse_set(AW'($urandom));
      b = 8'($urandom);
      send(b, $urandom_range(7) != 0);
      tick($urandom_range(50));
    end
    tick(4);
    chk("rnd_wc", wordCount, mdl_cnt);
    chk("rnd_err", err, mdl_err);

    // 7: reset during DATA of the 3rd byte
    pulse_set(12'h050);
    send(8'h9A, 1); send(8'hBC, 1);
    serialIn = 1'b0; tick(CPB);
    serialIn = 1'b1; tick(CPB);
    serialIn = 1'b0; tick(CPB);
    reset = 1'b1; serialIn = 1'b1;
    tick(2);
    check_reset_vals("rst7");
    reset = 1'b0;
    model_set('0);
    tick(5);
    send(8'hA1, 1); send(8'hB2, 1); send(8'hC3, 1); send(8'hD4, 1);
    tick(10);
    chk("t7_wc", wordCount, mdl_cnt);

    chk("bytes_drained", exp_bytes.size(), 0);
    chk("writes_drained", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
